// File: rtl/switch_onehot_encoder_pkg.sv
// -----------------------------------------------------------------------------
// switch_onehot_encoder_pkg
// Shared types and helpers for the slide-switch one-hot encoder.
//   state_e         : debounce FSM state encoding (STABLE / SETTLE)
//   onehot_to_code  : 8-bit vector -> 3-bit index of the lowest set bit
//   popcount8       : number of set bits in an 8-bit vector
// -----------------------------------------------------------------------------
package switch_onehot_encoder_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_SETTLE = 1'b1
   } state_e;

   // Scanning from the top down lets the lowest set bit overwrite the result.
   function automatic logic [2:0] onehot_to_code(input logic [7:0] v);
      logic [2:0] c;
      c = '0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) c = 3'(i);
      end
      return c;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/switch_onehot_encoder_sw_sync.sv
// -----------------------------------------------------------------------------
// switch_onehot_encoder_sw_sync
// Parameterized-width two-flop synchronizer for asynchronous switch levels.
// Ports:
//   i_clk  : destination clock
//   i_rst  : synchronous, active-high reset (clears both stages)
//   i_d    : asynchronous input bus
//   o_q    : synchronized bus (second flop stage)
// -----------------------------------------------------------------------------
module switch_onehot_encoder_sw_sync #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/switch_onehot_encoder.sv
// -----------------------------------------------------------------------------
// switch_onehot_encoder
// Synchronizes and debounces 8 slide switches, then encodes the accepted
// vector to a 3-bit index with valid/err flags and a change strobe.
//
// state   | meaning
// --------+----------------------------------------------------------------
// STABLE  | synchronized switches match the accepted vector
// SETTLE  | a new candidate vector is being timed for DEBOUNCE_CYCLES clocks
//
// Ports:
//   clk     : 100 MHz system clock
//   resetSW : synchronous, active-high reset
//   sw      : raw asynchronous switch levels
//   code    : index of the set bit (held when no single bit is set)
//   valid   : accepted vector has exactly one bit set
//   err     : accepted vector has two or more bits set
//   strobe  : one-cycle pulse when {valid, err, code} changes
//
// Build option: SWITCH_PRIORITY_RESOLVE_EN resolves multi-bit vectors to the
// lowest set index (valid=1, err=0) instead of flagging an error.
// -----------------------------------------------------------------------------
module switch_onehot_encoder
   import switch_onehot_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       resetSW,
   input  logic [7:0] sw,
   output logic [2:0] code,
   output logic       valid,
   output logic       err,
   output logic       strobe
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0]       w_sync2;
   logic [7:0]       r_accepted;
   logic [7:0]       r_candidate;
   logic [CNT_W-1:0] r_cnt;
   state_e           r_state;

   logic [2:0]       r_code;
   logic             r_valid;
   logic             r_err;
   logic             r_strobe;

   logic [3:0]       w_pop;
   logic [2:0]       w_code_nxt;
   logic             w_valid_nxt;
   logic             w_err_nxt;
   logic             w_changed;

   switch_onehot_encoder_sw_sync #(.W(8)) u_sw_sync (
      .i_clk (clk),
      .i_rst (resetSW),
      .i_d   (sw),
      .o_q   (w_sync2)
   );

   always_ff @(posedge clk) begin
      if (resetSW) begin
         r_state     <= ST_STABLE;
         r_accepted  <= '0;
         r_candidate <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_STABLE: begin
               if (w_sync2 != r_accepted) begin
                  r_candidate <= w_sync2;
                  r_cnt       <= '0;
                  r_state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // Returning to the accepted value is a glitch, not a change.
               if (w_sync2 == r_accepted) begin
                  r_state <= ST_STABLE;
               end else if (w_sync2 != r_candidate) begin
                  r_candidate <= w_sync2;
                  r_cnt       <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_accepted <= r_candidate;
                  r_state    <= ST_STABLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_STABLE;
         endcase
      end
   end

   assign w_pop = popcount8(r_accepted);

   always_comb begin
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_code_nxt  = r_code;
      if (w_pop == 4'd1) begin
         w_valid_nxt = 1'b1;
         w_code_nxt  = onehot_to_code(r_accepted);
      end else if (w_pop >= 4'd2) begin
`ifdef SWITCH_PRIORITY_RESOLVE_EN
         w_valid_nxt = 1'b1;
         w_code_nxt  = onehot_to_code(r_accepted);
`else
         w_err_nxt   = 1'b1;
`endif
      end
   end

   assign w_changed = {w_valid_nxt, w_err_nxt, w_code_nxt} != {r_valid, r_err, r_code};

   always_ff @(posedge clk) begin
      if (resetSW) begin
         r_code   <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_strobe <= 1'b0;
      end else begin
         r_code   <= w_code_nxt;
         r_valid  <= w_valid_nxt;
         r_err    <= w_err_nxt;
         r_strobe <= w_changed;
      end
   end

   assign code   = r_code;
   assign valid  = r_valid;
   assign err    = r_err;
   assign strobe = r_strobe;

endmodule

// File: tb/tb_switch_onehot_encoder.sv
module tb_switch_onehot_encoder;

   localparam int DB  = 4;
   localparam int LAT = DB + 4;   // posedges from drive until strobe seen

   logic       clk = 1'b0;
   logic       resetSW = 1'b1;
   logic [7:0] sw = 8'h00;
   logic [2:0] code;
   logic       valid;
   logic       err;
   logic       strobe;

   always #5 clk = ~clk;

   switch_onehot_encoder #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
      .clk     (clk),
      .resetSW (resetSW),
      .sw      (sw),
      .code    (code),
      .valid   (valid),
      .err     (err),
      .strobe  (strobe)
   );

   typedef struct packed {
      logic [2:0] code;
      logic       valid;
      logic       err;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the strobe caused by the last drive, then pops the scoreboard.
   task automatic wait_change(input string tag);
      int   n;
      logic got;
      exp_t e;
      n   = 0;
      got = 1'b0;
      while (n < 40 && !got) begin
         tick();
         n++;
         if (strobe) got = 1'b1;
      end
      chk({tag, "_strobe_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, 32'(n), 32'(LAT));
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_code"},  32'(code),  32'(e.code));
         chk({tag, "_valid"}, 32'(valid), 32'(e.valid));
         chk({tag, "_err"},   32'(err),   32'(e.err));
         cur = e;
      end else begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end
      tick();
      chk({tag, "_strobe_width"}, 32'(strobe), 32'd0);
   endtask

   task automatic quiet(input string tag, input int n);
      int strobes;
      int moved;
      strobes = 0;
      moved   = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (strobe) strobes++;
         if ({code, valid, err} !== cur) moved++;
      end
      chk({tag, "_no_strobe"}, 32'(strobes), 32'd0);
      chk({tag, "_no_change"}, 32'(moved), 32'd0);
   endtask

   initial begin
      int toggles;
      cur = '0;

      // Reset with switches low
      tick(); tick(); tick();
      chk("rst_code",   32'(code),   32'd0);
      chk("rst_valid",  32'(valid),  32'd0);
      chk("rst_err",    32'(err),    32'd0);
      chk("rst_strobe", 32'(strobe), 32'd0);
      resetSW = 1'b0;
      quiet("idle", 20);

      // Single switch accepted
      sw = 8'h20;
      sb_q.push_back('{code: 3'd5, valid: 1'b1, err: 1'b0});
      wait_change("sw20");
      quiet("sw20_hold", 5);

      // Short glitch back to the accepted value is rejected
      sw = 8'h08;
      tick(); tick(); tick();
      sw = 8'h20;
      quiet("glitch", 20);

      // Toggling never settles; final hold is accepted
      toggles = 0;
      for (int seg = 0; seg < 10; seg++) begin
         sw = (seg % 2 == 0) ? 8'h02 : 8'h01;
         tick(); if (strobe) toggles++;
         tick(); if (strobe) toggles++;
      end
      chk("toggle_no_strobe", 32'(toggles), 32'd0);
      sw = 8'h02;
      sb_q.push_back('{code: 3'd1, valid: 1'b1, err: 1'b0});
      wait_change("sw02");

      // Multi-bit vectors
`ifdef SWITCH_PRIORITY_RESOLVE_EN
      sw = 8'h06;
      quiet("sw06_same_enc", 20);
      sw = 8'h0C;
      sb_q.push_back('{code: 3'd2, valid: 1'b1, err: 1'b0});
      wait_change("sw0C");
`else
      sw = 8'h06;
      sb_q.push_back('{code: 3'd1, valid: 1'b0, err: 1'b1});
      wait_change("sw06");
      sw = 8'h0C;
      quiet("sw0C_same_enc", 20);
`endif

      // Reset while settling with cnt=2, then re-accept after release
      sw = 8'h40;
      quiet("sw40_settle", 5);
      resetSW = 1'b1;
      tick();
      resetSW = 1'b0;
      chk("midrst_code",   32'(code),   32'd0);
      chk("midrst_valid",  32'(valid),  32'd0);
      chk("midrst_err",    32'(err),    32'd0);
      chk("midrst_strobe", 32'(strobe), 32'd0);
      cur = '0;
      sb_q.push_back('{code: 3'd6, valid: 1'b1, err: 1'b0});
      wait_change("sw40_after_rst");

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
